// File: rtl/mem_arbiter.sv
// Two-port (CPU / debug loader) arbiter in front of a single data memory with a
// fixed read latency. Round-robin on ties; one transaction in flight at a time.
module mem_arbiter #(
  parameter int MEM_LAT = 1,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_done,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_done,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_e;

  localparam logic       OWN_CPU  = 1'b0;
  localparam logic       OWN_DBG  = 1'b1;
  localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

  state_e        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          last_owner_q, last_owner_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          cpu_gnt_q, cpu_gnt_d, dbg_gnt_q, dbg_gnt_d;
  logic          cpu_done_q, cpu_done_d, dbg_done_q, dbg_done_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;
  logic          winner_s;

  // State register and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      last_owner_q <= OWN_DBG;
      owner_q      <= OWN_CPU;
      we_q         <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_gnt_q    <= 1'b0;
      dbg_gnt_q    <= 1'b0;
      cpu_done_q   <= 1'b0;
      dbg_done_q   <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_gnt_q    <= cpu_gnt_d;
      dbg_gnt_q    <= dbg_gnt_d;
      cpu_done_q   <= cpu_done_d;
      dbg_done_q   <= dbg_done_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  // Next-state logic; gnt/done/mem_we are single-cycle pulses unless set below
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    we_d         = we_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_gnt_d    = 1'b0;
    dbg_gnt_d    = 1'b0;
    cpu_done_d   = 1'b0;
    dbg_done_d   = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;

    if (cpu_req && dbg_req) begin
      winner_s = ~last_owner_q;
    end else if (dbg_req) begin
      winner_s = OWN_DBG;
    end else begin
      winner_s = OWN_CPU;
    end

    case (state_q)
      IDLE, RESP: begin
        if (cpu_req || dbg_req) begin
          state_d      = ACCESS;
          owner_d      = winner_s;
          last_owner_d = winner_s;
          cnt_d        = CNT_INIT;
          if (winner_s == OWN_DBG) begin
            we_d        = dbg_we;
            mem_we_d    = dbg_we;
            mem_addr_d  = dbg_addr;
            mem_wdata_d = dbg_wdata;
            dbg_gnt_d   = 1'b1;
          end else begin
            we_d        = cpu_we;
            mem_we_d    = cpu_we;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
            cpu_gnt_d   = 1'b1;
          end
        end else begin
          state_d     = IDLE;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
        end
      end
      ACCESS: begin
        if (cnt_q == 2'd0) begin
          state_d     = RESP;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          if (owner_q == OWN_DBG) begin
            dbg_done_d = 1'b1;
            if (!we_q) begin
              dbg_rdata_d = mem_rdata;
            end else begin
              dbg_rdata_d = dbg_rdata_q;
            end
          end else begin
            cpu_done_d = 1'b1;
            if (!we_q) begin
              cpu_rdata_d = mem_rdata;
            end else begin
              cpu_rdata_d = cpu_rdata_q;
            end
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: begin
        state_d     = IDLE;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
      end
    endcase
  end

  assign cpu_gnt   = cpu_gnt_q;
  assign dbg_gnt   = dbg_gnt_q;
  assign cpu_done  = cpu_done_q;
  assign dbg_done  = dbg_done_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_stall = cpu_req & ~cpu_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table-driven single transactions plus round-robin,
// reset-abort, glitch-request and latency (MEM_LAT=1/4) sequences.
module tb_mem_arbiter;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] cpu_addr = 32'd0, cpu_wdata = 32'd0, dbg_addr = 32'd0, dbg_wdata = 32'd0;
  logic [31:0] mem_rdata = 32'd0;

  logic cpu_gnt, cpu_done, cpu_stall, dbg_gnt, dbg_done, mem_we;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata;
  logic a1_cpu_gnt, a1_cpu_done, a1_cpu_stall, a1_dbg_gnt, a1_dbg_done, a1_mem_we;
  logic [31:0] a1_cpu_rdata, a1_dbg_rdata, a1_mem_addr, a1_mem_wdata;
  logic a4_cpu_gnt, a4_cpu_done, a4_cpu_stall, a4_dbg_gnt, a4_dbg_done, a4_mem_we;
  logic [31:0] a4_cpu_rdata, a4_dbg_rdata, a4_mem_addr, a4_mem_wdata;

  mem_arbiter #(.MEM_LAT(LAT), .AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_done(dbg_done), .dbg_rdata(dbg_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  mem_arbiter #(.MEM_LAT(1), .AW(32), .DW(32)) dut_lat1 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(a1_cpu_gnt), .cpu_done(a1_cpu_done), .cpu_rdata(a1_cpu_rdata), .cpu_stall(a1_cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(a1_dbg_gnt), .dbg_done(a1_dbg_done), .dbg_rdata(a1_dbg_rdata),
    .mem_we(a1_mem_we), .mem_addr(a1_mem_addr), .mem_wdata(a1_mem_wdata), .mem_rdata(mem_rdata));

  mem_arbiter #(.MEM_LAT(4), .AW(32), .DW(32)) dut_lat4 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(a4_cpu_gnt), .cpu_done(a4_cpu_done), .cpu_rdata(a4_cpu_rdata), .cpu_stall(a4_cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(a4_dbg_gnt), .dbg_done(a4_dbg_done), .dbg_rdata(a4_dbg_rdata),
    .mem_we(a4_mem_we), .mem_addr(a4_mem_addr), .mem_wdata(a4_mem_wdata), .mem_rdata(mem_rdata));

  typedef struct {
    bit          dbg;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrd;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    bit          dbg;
    logic [31:0] rdata;
  } sb_t;

  sb_t sb[$];
  int  n_checks = 0;
  int  n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding transaction
  always @(negedge clk) begin
    if (rst_n) begin
      check("gnt_exclusive", {31'd0, cpu_gnt & dbg_gnt}, 32'd0);
      if (cpu_done || dbg_done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", {30'd0, cpu_done, dbg_done}, 32'd0);
        end else begin
          sb_t e;
          e = sb.pop_front();
          check("done_owner", {30'd0, cpu_done, dbg_done}, e.dbg ? 32'd1 : 32'd2);
          check("done_rdata", e.dbg ? dbg_rdata : cpu_rdata, e.rdata);
        end
      end
    end
  end

  task automatic do_reset();
    cpu_req = 1'b0; dbg_req = 1'b0; cpu_we = 1'b0; dbg_we = 1'b0;
    cpu_addr = 32'd0; dbg_addr = 32'd0; cpu_wdata = 32'd0; dbg_wdata = 32'd0;
    rst_n = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_txn(input vec_t v);
    sb_t it;
    @(posedge clk); #1;
    if (v.dbg) begin
      dbg_req = 1'b1; dbg_we = v.we; dbg_addr = v.addr; dbg_wdata = v.wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    mem_rdata = v.mrd;
    @(negedge clk);
    check("gnt_before_accept", {30'd0, cpu_gnt, dbg_gnt}, 32'd0);
    check("stall_c0", {31'd0, cpu_stall}, {31'd0, !v.dbg});
    for (int c = 1; c <= LAT + 1; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        it.dbg = v.dbg; it.rdata = v.exp_rdata;
        sb.push_back(it);
      end
      if (c == LAT + 1) begin
        cpu_req = 1'b0; dbg_req = 1'b0;
      end
      @(negedge clk);
      check("own_gnt", {31'd0, v.dbg ? dbg_gnt : cpu_gnt}, {31'd0, c == 1});
      check("other_gnt", {31'd0, v.dbg ? cpu_gnt : dbg_gnt}, 32'd0);
      check("mem_we", {31'd0, mem_we}, {31'd0, (c == 1) && v.we});
      check("mem_addr", mem_addr, (c <= LAT) ? v.addr : 32'd0);
      check("mem_wdata", mem_wdata, (c <= LAT) ? v.wdata : 32'd0);
      check("own_done", {31'd0, v.dbg ? dbg_done : cpu_done}, {31'd0, c == LAT + 1});
      check("cpu_stall", {31'd0, cpu_stall}, {31'd0, !v.dbg && (c < LAT + 1)});
    end
  endtask

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{dbg: 1'b0, we: 1'b0, addr: 32'h10,       wdata: 32'h0,        mrd: 32'hDEADBEEF, exp_rdata: 32'hDEADBEEF};
    vecs[1] = '{dbg: 1'b1, we: 1'b1, addr: 32'h20,       wdata: 32'h1234,     mrd: 32'h11111111, exp_rdata: 32'h0};
    vecs[2] = '{dbg: 1'b0, we: 1'b1, addr: 32'h44,       wdata: 32'hCAFEF00D, mrd: 32'h22222222, exp_rdata: 32'hDEADBEEF};
    vecs[3] = '{dbg: 1'b1, we: 1'b0, addr: 32'h80,       wdata: 32'h0,        mrd: 32'h5A5A1234, exp_rdata: 32'h5A5A1234};
    vecs[4] = '{dbg: 1'b0, we: 1'b0, addr: 32'hFFFFFFFC, wdata: 32'h0,        mrd: 32'h00000001, exp_rdata: 32'h00000001};
    vecs[5] = '{dbg: 1'b1, we: 1'b1, addr: 32'h0,        wdata: 32'hFFFFFFFF, mrd: 32'h33333333, exp_rdata: 32'h5A5A1234};

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("rst_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
    check("rst_dones", {30'd0, cpu_done, dbg_done}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_dbg_rdata", dbg_rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vecs[i]) run_txn(vecs[i]);

    // Both requesting continuously: CPU, DBG, CPU, DBG
    do_reset();
    @(posedge clk); #1;
    cpu_req = 1'b1; dbg_req = 1'b1; cpu_addr = 32'h100; dbg_addr = 32'h200;
    mem_rdata = 32'h0BADC0DE;
    for (int k = 0; k < 4; k++) sb.push_back('{dbg: k[0], rdata: 32'h0BADC0DE});
    for (int c = 1; c <= 13; c++) begin
      @(posedge clk); #1;
      if (c == 12) begin
        cpu_req = 1'b0; dbg_req = 1'b0;
      end
      @(negedge clk);
      check("rr_cpu_gnt", {31'd0, cpu_gnt}, {31'd0, c == 1 || c == 7});
      check("rr_dbg_gnt", {31'd0, dbg_gnt}, {31'd0, c == 4 || c == 10});
      check("rr_cpu_done", {31'd0, cpu_done}, {31'd0, c == 3 || c == 9});
      check("rr_dbg_done", {31'd0, dbg_done}, {31'd0, c == 6 || c == 12});
    end
    check("rr_sb_empty", sb.size(), 32'd0);

    // Reset during ACCESS of a CPU store aborts it
    do_reset();
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h55; cpu_wdata = 32'h77;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(negedge clk);
    check("abort_pre_mem_we", {31'd0, mem_we}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_gnt", {31'd0, cpu_gnt}, 32'd0);
    check("abort_mem_we", {31'd0, mem_we}, 32'd0);
    check("abort_mem_addr", mem_addr, 32'd0);
    check("abort_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("abort_idle", {29'd0, cpu_done, mem_we, cpu_gnt}, 32'd0);
      check("abort_idle_addr", mem_addr, 32'd0);
    end
    @(posedge clk); #1;
    cpu_req = 1'b1; dbg_req = 1'b1; cpu_we = 1'b0; dbg_we = 1'b0; mem_rdata = 32'h600DF00D;
    sb.push_back('{dbg: 1'b0, rdata: 32'h600DF00D});
    @(posedge clk); #1;
    cpu_req = 1'b0; dbg_req = 1'b0;
    @(negedge clk);
    check("fresh_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
    check("fresh_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
    for (int i = 0; i < 8 && sb.size() != 0; i++) @(negedge clk);
    check("fresh_done_timeout", sb.size(), 32'd0);

    // Debug request glitch between edges must be ignored
    @(posedge clk); #2;
    dbg_addr = 32'hABC; dbg_we = 1'b1; dbg_wdata = 32'h99; dbg_req = 1'b1;
    #2 dbg_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("glitch_quiet", {29'd0, dbg_gnt, dbg_done, mem_we}, 32'd0);
      check("glitch_mem_addr", mem_addr, 32'd0);
    end

    // Latency: MEM_LAT 1 / 2 / 4 loads, capture from the last ACCESS cycle
    do_reset();
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h30; mem_rdata = 32'hA0000000;
    sb.push_back('{dbg: 1'b0, rdata: 32'hA0000002});
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c == 1) cpu_req = 1'b0;
      mem_rdata = 32'hA0000000 | 32'(c);
      @(negedge clk);
      check("lat1_done", {31'd0, a1_cpu_done}, {31'd0, c == 2});
      check("lat4_done", {31'd0, a4_cpu_done}, {31'd0, c == 5});
      check("lat4_mem_addr", a4_mem_addr, (c <= 4) ? 32'h30 : 32'd0);
      if (c == 2) check("lat1_rdata", a1_cpu_rdata, 32'hA0000001);
      if (c == 5) check("lat4_rdata", a4_cpu_rdata, 32'hA0000004);
    end
    check("final_sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 1, data-memory read latency in cycles, legal range 1..4.
REQ-002 Parameter AW, default 32, address width.
REQ-003 Parameter DW, default 32, data width.
REQ-004 Clock  input  1  single clock; all state updates on rising edge.
REQ-005 Reset  input  1  asynchronous, active-low; clears all state immediately on assertion.
REQ-006 cpu_req / cpu_we  input  1 / 1  CPU load/store request; we=1 store, we=0 load.
REQ-007 cpu_addr / cpu_wdata  input  AW / DW  CPU address and store data.
REQ-008 cpu_gnt / cpu_done  output  1 / 1  CPU request accepted; CPU transaction complete.
REQ-009 cpu_rdata  output  DW  CPU load data, valid when cpu_done=1 for a load.
REQ-010 cpu_stall  output  1  CPU must hold PC/pipeline this cycle.
REQ-011 dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_done, dbg_rdata: same widths/meanings as the cpu_* set, for the debug/program-loader port.
REQ-012 mem_we  output  1  data-memory write strobe.
REQ-013 mem_addr / mem_wdata  output  AW / DW  data-memory address and write data.
REQ-014 mem_rdata  input  DW  data-memory read data.

Function
REQ-015 The block SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-016 In IDLE or RESP, on a clock edge with any req=1, the block SHALL accept one request, latch its we/addr/wdata and owner, and enter ACCESS; with no req it SHALL enter/remain IDLE.
REQ-017 Arbitration: single requester wins; both requesting -> the port not equal to last_owner wins (round-robin); last_owner updates on every acceptance.
REQ-018 Requests SHALL be sampled only at accepting edges; a req deasserted before acceptance SHALL produce no transaction.
REQ-019 The owner's gnt SHALL be 1 for exactly the first ACCESS cycle; the non-owner's gnt SHALL stay 0.
REQ-020 The requester SHALL hold req/we/addr/wdata stable until gnt; after gnt they are don't-care.
REQ-021 ACCESS SHALL last exactly MEM_LAT cycles (internal down-counter, width 2 bits); mem_addr/mem_wdata SHALL drive latched values throughout ACCESS.
REQ-022 mem_we SHALL be 1 only in the first ACCESS cycle of a store; 0 at all other times.
REQ-023 On the edge ending the last ACCESS cycle, a load SHALL capture mem_rdata into the owner's rdata register; then enter RESP.
REQ-024 In RESP the owner's done SHALL be 1 for exactly one cycle (loads and stores); rdata registers SHALL hold their value until the next load capture for that port.
REQ-025 Transaction latency: acceptance edge -> done cycle = MEM_LAT+1 cycles; back-to-back throughput one transaction per MEM_LAT+1 cycles via acceptance in RESP.
REQ-026 cpu_stall SHALL equal cpu_req AND NOT cpu_done (combinational).
REQ-027 Outside ACCESS, mem_addr and mem_wdata SHALL be 0.

Reset
REQ-028 On Reset=0: state=IDLE, counter=0, last_owner=DBG (CPU wins first tie), all gnt/done/mem_we=0, mem_addr/mem_wdata=0, cpu_rdata/dbg_rdata=0.
REQ-029 Reset mid-transaction SHALL abort it: no done pulse, no further mem_we; the first edge after release with req=1 starts a fresh arbitration.

Verification (MEM_LAT=2 unless stated)
REQ-030 CPU load addr 0x10, mem_rdata=0xDEADBEEF -> cpu_gnt at cycle 1, cpu_done cycle 3 with cpu_rdata=0xDEADBEEF, mem_we never 1, cpu_stall 1 cycles 0-2.
REQ-031 DBG store addr 0x20 data 0x1234 -> mem_we=1 only in cycle 1 with mem_addr=0x20, mem_wdata=0x1234; dbg_done cycle 3.
REQ-032 Both req continuously after reset -> grant order CPU, DBG, CPU, DBG; one done every 3 cycles; never both gnt in a cycle.
REQ-033 Reset pulled low during ACCESS of a CPU store -> all outputs 0 immediately, no cpu_done, state IDLE after release.
REQ-034 MEM_LAT=1 and MEM_LAT=4 loads -> done exactly 2 and 5 cycles after acceptance edge, data captured from mem_rdata on last ACCESS cycle.
REQ-035 dbg_req pulsed one cycle between edges (not present at any edge) -> no dbg_gnt, no memory activity.
